ntt_ctrl_fsm: RTL

- Parametrised radix-2 NTT/INTT/PWM sequencing controller for the butterfly datapath and its memory banks.
- Generates per-cycle stage/group/index (p, k, i) addresses.
- Issues read/butterfly enables, delays write enables by the datapath pipeline depth and drains the pipeline.
- Adds a start/busy/done handshake, a stall input and configurable transform size over the previous fixed-size controller.

---
 rtl/ntt_ctrl_if.sv | 33 +++
 rtl/ntt_ctrl_fsm.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ntt_ctrl_if.sv
// Handshake and address bundle between an NTT sequencing controller and its datapath.
// Latency: none, wiring only.
// Backpressure: the stall input from the datapath side freezes issue; outputs are owned by the controller.
interface ntt_ctrl_if #(
  parameter int LOGH = 9,
  parameter int P_W  = $clog2(LOGH + 1)
);
  logic            start;
  logic [1:0]      mode;
  logic            stall;
  logic            busy;
  logic            issue;
  logic [P_W-1:0]  p;
  logic [LOGH-1:0] k;
  logic [LOGH-1:0] i;
  logic            sel;
  logic            wen;
  logic            done;
  logic [1:0]      done_mode;
  logic            err;

  // Requester side: drives start/mode/stall, observes progress.
  modport master (
    output start, mode, stall,
    input  busy, issue, p, k, i, sel, wen, done, done_mode, err
  );

  // Controller side.
  modport slave (
    input  start, mode, stall,
    output busy, issue, p, k, i, sel, wen, done, done_mode, err
  );
endinterface

// File: rtl/ntt_ctrl_fsm.sv
// Radix-2 NTT/INTT/PWM sequencer: emits (p,k,i) per issued op, write enables and a done pulse.
// Latency: first issue the cycle after start; wen trails issue by PIPE_DEPTH; done one cycle after the last wen.
// Backpressure: stall freezes issue and counters in RUN; the wen pipe keeps shifting; stall is ignored in DRAIN.
module ntt_ctrl_fsm #(
  parameter int LOGH       = 9,
  parameter int PIPE_DEPTH = 8,
  parameter int P_W        = $clog2(LOGH + 1)
) (
  input logic       clk,
  input logic       rst,
  ntt_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [1:0]      M_NTT  = 2'b00;
  localparam logic [1:0]      M_PWM  = 2'b01;
  localparam logic [1:0]      M_INTT = 2'b10;
  localparam logic [1:0]      M_RSV  = 2'b11;
  localparam int              DW     = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [DW-1:0]   DRAIN_LAST = DW'(PIPE_DEPTH - 1);
  // Boundary arithmetic is done one bit wider than k/i so H itself is representable.
  localparam logic [LOGH:0]   ONE    = {{LOGH{1'b0}}, 1'b1};
  localparam logic [LOGH:0]   H_L    = {1'b1, {LOGH{1'b0}}};
  localparam logic [P_W-1:0]  P_TOP  = P_W'(LOGH);

  state_t          state_q, state_d;
  logic [P_W-1:0]  p_q, p_d;
  logic [LOGH-1:0] k_q, k_d;
  logic [LOGH-1:0] i_q, i_d;
  logic [1:0]      mode_q, mode_d;
  logic            sel_q, sel_d;
  logic            err_q, err_d;
  logic [DW-1:0]   drain_q, drain_d;
  logic            issue_c;
  logic [PIPE_DEPTH-1:0] wen_sr;

  logic [LOGH:0]   i_max, k_max;
  logic            i_end, k_end, p_end, last_op;

  // i spans 2^p per group, k spans H>>p groups per stage.
  assign i_max   = (ONE << p_q) - ONE;
  assign k_max   = (H_L >> p_q) - ONE;
  assign i_end   = ({1'b0, i_q} == i_max);
  assign k_end   = ({1'b0, k_q} == k_max);
  assign p_end   = (mode_q == M_INTT) ? (p_q == P_TOP) : (p_q == '0);
  assign last_op = (mode_q == M_PWM) ? (&k_q) : (p_end && k_end && i_end);

  // Next-state, counter advance and issue decode.
  always_comb begin
    state_d = state_q;
    p_d     = p_q;
    k_d     = k_q;
    i_d     = i_q;
    mode_d  = mode_q;
    sel_d   = sel_q;
    drain_d = drain_q;
    err_d   = 1'b0;
    issue_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode == M_RSV) begin
            err_d = 1'b1;
          end else begin
            mode_d  = bus.mode;
            sel_d   = (bus.mode == M_INTT);
            p_d     = (bus.mode == M_NTT) ? P_TOP : '0;
            k_d     = '0;
            i_d     = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        issue_c = !bus.stall;
        if (!bus.stall) begin
          if (last_op) begin
            // Counters park at zero for DRAIN/DONE.
            p_d     = '0;
            k_d     = '0;
            i_d     = '0;
            drain_d = '0;
            state_d = DRAIN;
          end else if (mode_q == M_PWM) begin
            k_d = k_q + LOGH'(1);
          end else if (i_end) begin
            i_d = '0;
            if (k_end) begin
              k_d = '0;
              p_d = (mode_q == M_INTT) ? p_q + P_W'(1) : p_q - P_W'(1);
            end else begin
              k_d = k_q + LOGH'(1);
            end
          end else begin
            i_d = i_q + LOGH'(1);
          end
        end
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
        else                       drain_d = drain_q + DW'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and counter registers; reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      p_q     <= '0;
      k_q     <= '0;
      i_q     <= '0;
      mode_q  <= M_NTT;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      k_q     <= k_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      drain_q <= drain_d;
    end
  end

  // Write-enable delay line: shifts every cycle so stall gaps reappear in wen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wen_sr <= '0;
    end else begin
      wen_sr[0] <= issue_c;
      for (int j = 1; j < PIPE_DEPTH; j++) wen_sr[j] <= wen_sr[j-1];
    end
  end

  assign bus.busy      = (state_q == RUN) || (state_q == DRAIN);
  assign bus.issue     = issue_c;
  assign bus.p         = p_q;
  assign bus.k         = k_q;
  assign bus.i         = i_q;
  assign bus.sel       = sel_q;
  assign bus.wen       = wen_sr[PIPE_DEPTH-1];
  assign bus.done      = (state_q == DONE);
  assign bus.done_mode = (state_q == DONE) ? mode_q : 2'b00;
  assign bus.err       = err_q;

endmodule
